// File: rtl/wb_sram_slave.sv
// Wishbone B4 slave in front of a single-port synchronous SRAM.
// Handles classic cycles and registered-feedback linear/wrapping bursts.
module wb_sram_slave #(
    parameter int unsigned WB_ADDR_WIDTH = 32,
    parameter int unsigned WB_DATA_WIDTH = 32,
    parameter int unsigned MEM_ADDR_BITS = 10,
    parameter int unsigned WAIT_STATES   = 0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [WB_ADDR_WIDTH-1:0]   ADR,
    input  logic [2:0]                 CTI,
    input  logic [1:0]                 BTE,
    input  logic [WB_DATA_WIDTH-1:0]   DAT_W,
    output logic [WB_DATA_WIDTH-1:0]   DAT_R,
    input  logic                       CYC,
    input  logic                       STB,
    input  logic [WB_DATA_WIDTH/8-1:0] SEL,
    input  logic                       WE,
    output logic                       ACK,
    output logic                       ERR
);

    localparam int unsigned NumBytes = WB_DATA_WIDTH / 8;
    localparam int unsigned Lsb      = $clog2(NumBytes);
    localparam int unsigned Depth    = 1 << MEM_ADDR_BITS;

    typedef enum logic [1:0] {StIdle, StWait, StResp, StBurst} state_e;

    state_e                     state_q, state_d;
    logic [MEM_ADDR_BITS-1:0]   addr_q, addr_d;
    logic [3:0]                 wait_q, wait_d;
    logic                       oor_q, oor_d;
    logic [WB_DATA_WIDTH-1:0]   dat_r_q, dat_r_d;

    logic [WB_DATA_WIDTH-1:0]   mem [Depth];

    logic                       bus_req;
    logic                       wr_en;
    logic                       load_rd;
    logic [MEM_ADDR_BITS-1:0]   adr_word;
    logic                       adr_oor;
    logic [MEM_ADDR_BITS-1:0]   wrap_mask;
    logic [MEM_ADDR_BITS-1:0]   next_addr;
    logic [WB_DATA_WIDTH-1:0]   rd_data;

    assign bus_req  = CYC & STB;
    assign adr_word = ADR[Lsb +: MEM_ADDR_BITS];
    assign adr_oor  = |(ADR >> (Lsb + MEM_ADDR_BITS));

    // Responses are gated by the live strobe so a dropped cycle never sees ACK/ERR.
    assign ACK   = bus_req & ~oor_q & ((state_q == StResp) | (state_q == StBurst));
    assign ERR   = bus_req & oor_q & (state_q == StResp);
    assign wr_en = ACK & WE;
    assign DAT_R = dat_r_q;

    // Wrap modes only increment the low bits; linear uses the full counter.
    always_comb begin
        wrap_mask = '1;
        case (BTE)
            2'b01:   wrap_mask = MEM_ADDR_BITS'(4'h3);
            2'b10:   wrap_mask = MEM_ADDR_BITS'(4'h7);
            2'b11:   wrap_mask = MEM_ADDR_BITS'(4'hF);
            default: wrap_mask = '1;
        endcase
        next_addr = (addr_q & ~wrap_mask) | ((addr_q + MEM_ADDR_BITS'(1)) & wrap_mask);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wait_d  = wait_q;
        oor_d   = oor_q;
        dat_r_d = dat_r_q;
        load_rd = 1'b0;
        rd_data = '0;

        case (state_q)
            StIdle: begin
                if (bus_req) begin
                    addr_d = adr_word;
                    oor_d  = adr_oor;
                    wait_d = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d = StResp;
                        load_rd = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                wait_d = wait_q - 4'd1;
                if (wait_q <= 4'd1) begin
                    state_d = StResp;
                    load_rd = 1'b1;
                end
            end
            StResp: begin
                if (STB && CTI == 3'b010 && !oor_q) begin
                    state_d = StBurst;
                    addr_d  = next_addr;
                    load_rd = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            StBurst: begin
                if (STB) begin
                    if (CTI == 3'b010) begin
                        addr_d  = next_addr;
                        load_rd = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (!CYC) begin
            state_d = StIdle;
            load_rd = 1'b0;
        end

        // Prefetch the next beat, forwarding any bytes written this cycle.
        rd_data = mem[addr_d];
        if (wr_en && addr_q == addr_d) begin
            for (int b = 0; b < NumBytes; b++) begin
                if (SEL[b]) rd_data[8*b +: 8] = DAT_W[8*b +: 8];
            end
        end
        if (load_rd && !oor_d) dat_r_d = rd_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wait_q  <= '0;
            oor_q   <= 1'b0;
            dat_r_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wait_q  <= wait_d;
            oor_q   <= oor_d;
            dat_r_q <= dat_r_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && wr_en) begin
            for (int b = 0; b < NumBytes; b++) begin
                if (SEL[b]) mem[addr_q][8*b +: 8] <= DAT_W[8*b +: 8];
            end
        end
    end

endmodule

// File: doc/wb_sram_slave.md
Name: wb_sram_slave

Overview:
- Single-port synchronous SRAM Wishbone B4 slave, sitting directly downstream of the NxN interconnect on any slave port (s0..s4).
- Supports classic single cycles and registered-feedback incrementing/wrapping bursts (CTI/BTE), so one burst beat per clock after the first.
- Standard local memory target for the team's SoC templates.

Parameters:
- WB_ADDR_WIDTH, 32, byte address width.
- WB_DATA_WIDTH, 32, data width; must be 8/16/32/64.
- MEM_ADDR_BITS, 10, log2 of memory depth in words.
- WAIT_STATES, 0, extra cycles inserted before the first ACK/ERR of each cycle or burst (0..15).

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous active-low reset.
- ADR  input  WB_ADDR_WIDTH  byte address.
- CTI  input  3  cycle type identifier.
- BTE  input  2  burst type extension.
- DAT_W  input  WB_DATA_WIDTH  write data.
- DAT_R  output  WB_DATA_WIDTH  read data.
- CYC  input  1  bus cycle.
- STB  input  1  strobe.
- SEL  input  WB_DATA_WIDTH/8  byte enables.
- WE  input  1  write enable.
- ACK  output  1  transfer acknowledge.
- ERR  output  1  error acknowledge.

Behaviour:
- Interface: one clock, clk; reset rstn is asynchronous, active-low.
- Reset values: ACK=0, ERR=0, DAT_R=0, FSM=IDLE, burst counter=0. Memory contents are not reset.
- Addressing: LSB = log2(WB_DATA_WIDTH/8); word index = ADR[LSB +: MEM_ADDR_BITS].
- Out-of-range: any set bit in ADR[WB_ADDR_WIDTH-1 : LSB+MEM_ADDR_BITS] gives ERR instead of ACK, with the same timing. No write occurs and DAT_R holds its previous value. A burst is terminated by ERR.
- Transfer rule: a transfer completes in a cycle where CYC & STB & (ACK|ERR). Writes commit on that cycle, gated per byte by SEL. Read DAT_R is valid while ACK=1.
- FSM states:
  - IDLE: on CYC&STB, latch word address into counter, load wait counter = WAIT_STATES, go WAIT (or go RESP if WAIT_STATES=0).
  - WAIT: decrement each cycle; at 0 go RESP.
  - RESP: ACK/ERR high for exactly this cycle.
    - If CTI=010 and STB=1 and no ERR: go BURST; counter advances.
    - Otherwise (CTI 000, 001, 011-110 treated as classic, or 111): go IDLE.
  - BURST: ACK=1 every cycle STB=1, with data for the counter address.
    - STB=0: ACK=0, counter held (master wait).
    - The beat acked with CTI=111 ends the burst: go IDLE.
- ACK/ERR latency:
  - First beat acked 1+WAIT_STATES cycles after CYC&STB is first sampled. Classic minimum is 1 wait cycle (ACK in the 2nd cycle of STB).
  - Burst beats: 1 per cycle, no wait states after the first beat.
- Classic back-to-back: the FSM passes through IDLE for one cycle; ACK never asserts on two consecutive classic cycles.
- Burst address: after the first beat, ADR is ignored and the internal counter is used. Counter advance by BTE:
  - 00 linear +1, wrapping at memory depth.
  - 01 wrap-4: low 2 bits increment mod 4.
  - 10 wrap-8: low 3 bits increment mod 8.
  - 11 wrap-16: low 4 bits increment mod 16.
  - Upper bits are held in all wrap modes.
- Read pipelining: the memory read address is the next counter value, so DAT_R is registered and correct in every ACK cycle.
- Read-after-write within a burst returns the new data.
- Dropped cycle: if CYC=0 in any state, go IDLE next cycle. ACK/ERR outputs are combinationally gated with CYC&STB, so no response is ever seen when CYC=0. A pending write is discarded.
- Reset mid-operation: outputs return to reset values asynchronously. A write on the same edge as reset assertion is not committed.

Test Plan:
- Classic write 0xDEADBEEF to 0x40 (SEL=1111), then classic read of 0x40: ACK exactly 1 cycle each, 2nd cycle of STB; read returns 0xDEADBEEF.
- Byte write SEL=0010 with DAT_W=0x0000AB00 to 0x40, then read: 0xDEADABEF.
- WAIT_STATES=3 classic read: ACK in cycle 5 after STB; ERR stays 0.
- Incrementing burst (CTI=010, BTE=00) at 0x10, 4 beats of write data 1,2,3,4, last beat CTI=111: ACK high 4 consecutive cycles after the first. A linear read burst at 0x10 returns 1,2,3,4 in consecutive cycles.
- Wrap-4 read burst starting at 0x18 (MEM preloaded with word index): beats return indices 6,7,4,5. Insert STB=0 for 2 cycles after beat 2: ACK=0 for those cycles and beat 3 resumes with index 4.
- Out-of-range read at 1<<(MEM_ADDR_BITS+2): ERR 1 cycle, ACK=0, memory unchanged. CYC dropped mid-burst after 2 beats: ACK=0 next cycle, FSM=IDLE. rstn pulsed low mid-burst: ACK/ERR/DAT_R=0 immediately.
